// File: rtl/player_bullet_ctl.sv
// player_bullet_ctl
// Launches one tank shell, advances it by SPEED pixels on every frame tick
// (rising edge of vsync), ends it at the screen edge or on a target hit, and
// then waits COOLDOWN_FRAMES ticks before accepting the next fire request.
//
// Ports:
//   clk, rst                  pixel clock, asynchronous active-high reset
//   vsync                     vertical sync; its rising edge is the frame tick
//   fire                      fire request level, sampled every clk
//   tank_dir                  1=up 2=down 3=right 4=left, other codes invalid
//   xpos_tank, ypos_tank      launch position
//   xpos_target, ypos_target  top-left corner of the target hit box
//   xpos_bullet, ypos_bullet  shell position (registered)
//   direction_out             0 when no shell is in flight, else shell type
//   hit_out                   one-clk pulse on a target strike
//   ready_out                 high only while idle
module player_bullet_ctl #(
    parameter int SPEED           = 4,
    parameter int X_MAX           = 799,
    parameter int Y_MAX           = 599,
    parameter int TANK_W          = 40,
    parameter int TANK_H          = 40,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       fire,
    input  logic [2:0] tank_dir,
    input  logic [9:0] xpos_tank,
    input  logic [9:0] ypos_tank,
    input  logic [9:0] xpos_target,
    input  logic [9:0] ypos_target,
    output logic [9:0] xpos_bullet,
    output logic [9:0] ypos_bullet,
    output logic [2:0] direction_out,
    output logic       hit_out,
    output logic       ready_out
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLYING   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam int CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    // All position arithmetic is 11 bits wide so edge tests never wrap.
    localparam logic [10:0] SPD11  = 11'(SPEED);
    localparam logic [10:0] XMAX11 = 11'(X_MAX);
    localparam logic [10:0] YMAX11 = 11'(Y_MAX);
    localparam logic [10:0] BOXW11 = 11'(TANK_W - 1);
    localparam logic [10:0] BOXH11 = 11'(TANK_H - 1);

    state_t           state_q;
    logic             vsync_q;
    logic [9:0]       x_q;
    logic [9:0]       y_q;
    logic [2:0]       dir_q;
    logic             hit_q;
    logic             ready_q;
    logic [CNT_W-1:0] cnt_q;

    logic             tick;
    logic             dir_ok;
    logic [10:0]      x_ext;
    logic [10:0]      y_ext;
    logic [10:0]      nx_d;
    logic [10:0]      ny_d;
    logic             oob_d;
    logic             in_box_d;

    assign tick   = vsync & ~vsync_q;
    assign dir_ok = (tank_dir >= 3'd1) && (tank_dir <= 3'd4);
    assign x_ext  = {1'b0, x_q};
    assign y_ext  = {1'b0, y_q};

    // Candidate next position, out-of-bounds test and hit-box test.
    always_comb begin
        nx_d  = x_ext;
        ny_d  = y_ext;
        oob_d = 1'b0;
        case (dir_q)
            3'd1: begin
                if (y_ext < SPD11) begin
                    oob_d = 1'b1;
                end else begin
                    ny_d = y_ext - SPD11;
                end
            end
            3'd2: begin
                ny_d = y_ext + SPD11;
                if (ny_d > YMAX11) begin
                    oob_d = 1'b1;
                end else begin
                    oob_d = 1'b0;
                end
            end
            3'd3: begin
                nx_d = x_ext + SPD11;
                if (nx_d > XMAX11) begin
                    oob_d = 1'b1;
                end else begin
                    oob_d = 1'b0;
                end
            end
            3'd4: begin
                if (x_ext < SPD11) begin
                    oob_d = 1'b1;
                end else begin
                    nx_d = x_ext - SPD11;
                end
            end
            // A corrupted heading ends the flight rather than moving blindly.
            default: oob_d = 1'b1;
        endcase
        in_box_d = (nx_d >= {1'b0, xpos_target}) &&
                   (nx_d <= ({1'b0, xpos_target} + BOXW11)) &&
                   (ny_d >= {1'b0, ypos_target}) &&
                   (ny_d <= ({1'b0, ypos_target} + BOXH11));
    end

    // Shell state machine with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vsync_q <= 1'b0;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            dir_q   <= 3'd0;
            hit_q   <= 1'b0;
            ready_q <= 1'b1;
            cnt_q   <= CNT_ZERO;
        end else begin
            vsync_q <= vsync;
            hit_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fire && dir_ok) begin
                        x_q     <= xpos_tank;
                        y_q     <= ypos_tank;
                        dir_q   <= tank_dir;
                        ready_q <= 1'b0;
                        state_q <= FLYING;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                FLYING: begin
                    if (tick) begin
                        if (oob_d) begin
                            // Position keeps its last legal value.
                            dir_q   <= 3'd0;
                            cnt_q   <= CNT_LOAD;
                            state_q <= COOLDOWN;
                        end else begin
                            x_q <= nx_d[9:0];
                            y_q <= ny_d[9:0];
                            if (in_box_d) begin
                                hit_q   <= 1'b1;
                                dir_q   <= 3'd0;
                                cnt_q   <= CNT_LOAD;
                                state_q <= COOLDOWN;
                            end else begin
                                state_q <= FLYING;
                            end
                        end
                    end else begin
                        state_q <= FLYING;
                    end
                end
                COOLDOWN: begin
                    // A zero load leaves on the first clk after entry; otherwise
                    // the tick that brings the counter to zero releases IDLE.
                    if (cnt_q == CNT_ZERO) begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else if (tick) begin
                        cnt_q <= cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            state_q <= COOLDOWN;
                        end
                    end else begin
                        state_q <= COOLDOWN;
                    end
                end
                default: begin
                    dir_q   <= 3'd0;
                    ready_q <= 1'b1;
                    cnt_q   <= CNT_ZERO;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign xpos_bullet   = x_q;
    assign ypos_bullet   = y_q;
    assign direction_out = dir_q;
    assign hit_out       = hit_q;
    assign ready_out     = ready_q;

endmodule

// File: tb/tb_player_bullet_ctl.sv
// Scoreboard bench for player_bullet_ctl. Stimulus pushes the expected output
// snapshot {x, y, dir, hit, ready} together with the clk count at which it
// must appear; the monitor pops one entry every time the outputs change.
module tb_player_bullet_ctl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vsync = 1'b0;
    logic       fire = 1'b0;
    logic [2:0] tank_dir = 3'd0;
    logic [9:0] xpos_tank = 10'd0;
    logic [9:0] ypos_tank = 10'd0;
    logic [9:0] xpos_target = 10'd700;
    logic [9:0] ypos_target = 10'd500;
    logic [9:0] xpos_bullet;
    logic [9:0] ypos_bullet;
    logic [2:0] direction_out;
    logic       hit_out;
    logic       ready_out;

    player_bullet_ctl dut (
        .clk(clk), .rst(rst), .vsync(vsync), .fire(fire), .tank_dir(tank_dir),
        .xpos_tank(xpos_tank), .ypos_tank(ypos_tank),
        .xpos_target(xpos_target), .ypos_target(ypos_target),
        .xpos_bullet(xpos_bullet), .ypos_bullet(ypos_bullet),
        .direction_out(direction_out), .hit_out(hit_out), .ready_out(ready_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [24:0] v;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    bit          first = 1'b1;
    logic [24:0] prev;
    logic [24:0] snap;
    exp_t        e;

    function automatic logic [24:0] pk(input int x, input int y, input int d,
                                       input bit h, input bit r);
        return {10'(x), 10'(y), 3'(d), h, r};
    endfunction

    task automatic expect_at(input logic [24:0] v, input int dc, input string nm);
        exp_t t;
        t.v    = v;
        t.cyc  = (dc < 0) ? -1 : cyc + dc;
        t.name = nm;
        q.push_back(t);
    endtask

    task automatic tick_start();
        @(negedge clk);
        vsync = 1'b1;
    endtask

    task automatic tick_end();
        @(negedge clk);
        vsync = 1'b0;
    endtask

    task automatic launch(input int x, input int y, input int d);
        @(negedge clk);
        xpos_tank = 10'(x);
        ypos_tank = 10'(y);
        tank_dir  = 3'(d);
        fire      = 1'b1;
        expect_at(pk(x, y, d, 1'b0, 1'b0), 1, "launch");
        @(negedge clk);
        fire = 1'b0;
    endtask

    task automatic cooldown(input int x, input int y);
        for (int i = 1; i <= 30; i++) begin
            tick_start();
            if (i == 30) expect_at(pk(x, y, 0, 1'b0, 1'b1), 1, "cool_ready");
            tick_end();
        end
    endtask

    // Monitor: every output change must match the next scoreboard entry.
    always @(negedge clk) begin
        if (mon_en) begin
            snap = {xpos_bullet, ypos_bullet, direction_out, hit_out, ready_out};
            if (first || snap !== prev) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_change: got %h at cyc %0d, required no change",
                             snap, cyc);
                end else begin
                    e = q.pop_front();
                    if (snap !== e.v || (e.cyc >= 0 && e.cyc != cyc)) begin
                        n_err++;
                        $display("FAIL %s: got %h at cyc %0d, required %h at cyc %0d",
                                 e.name, snap, cyc, e.v, e.cyc);
                    end
                end
            end
            prev  = snap;
            first = 1'b0;
        end
    end

    initial begin
        // Reset state.
        expect_at(pk(0, 0, 0, 1'b0, 1'b1), -1, "reset_state");
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Invalid headings never launch.
        @(negedge clk);
        xpos_tank = 10'd50; ypos_tank = 10'd50; tank_dir = 3'd0; fire = 1'b1;
        repeat (3) @(negedge clk);
        tank_dir = 3'd5;
        repeat (3) @(negedge clk);
        tank_dir = 3'd7;
        repeat (3) @(negedge clk);
        fire = 1'b0;

        // Fire together with a tick: launch wins, first move on the next tick.
        @(negedge clk);
        xpos_tank = 10'd200; ypos_tank = 10'd590; tank_dir = 3'd2;
        fire = 1'b1; vsync = 1'b1;
        expect_at(pk(200, 590, 2, 1'b0, 1'b0), 1, "launch_on_tick");
        @(negedge clk);
        fire = 1'b0; vsync = 1'b0;
        tick_start(); expect_at(pk(200, 594, 2, 1'b0, 1'b0), 1, "down_1"); tick_end();
        tick_start(); expect_at(pk(200, 598, 2, 1'b0, 1'b0), 1, "down_2"); tick_end();
        tick_start(); expect_at(pk(200, 598, 0, 1'b0, 1'b0), 1, "down_edge"); tick_end();
        cooldown(200, 598);

        // Left edge.
        launch(6, 300, 4);
        tick_start(); expect_at(pk(2, 300, 4, 1'b0, 1'b0), 1, "left_1"); tick_end();
        tick_start(); expect_at(pk(2, 300, 0, 1'b0, 1'b0), 1, "left_edge"); tick_end();
        cooldown(2, 300);

        // Up flight to y=0, then off the top.
        launch(100, 200, 1);
        for (int k = 1; k <= 50; k++) begin
            tick_start();
            expect_at(pk(100, 200 - 4 * k, 1, 1'b0, 1'b0), 1, "up_step");
            tick_end();
        end
        tick_start(); expect_at(pk(100, 0, 0, 1'b0, 1'b0), 1, "up_edge"); tick_end();

        // Cooldown with fire held: release on tick 30, relaunch next clk.
        @(negedge clk);
        xpos_tank = 10'd100; ypos_tank = 10'd120; tank_dir = 3'd1; fire = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick_start();
            if (i == 30) begin
                expect_at(pk(100, 0, 0, 1'b0, 1'b1), 1, "held_ready");
                expect_at(pk(100, 120, 1, 1'b0, 1'b0), 2, "held_relaunch");
            end
            tick_end();
        end
        @(negedge clk);
        fire = 1'b0;

        // Asynchronous reset mid-flight, between clock edges.
        @(posedge clk);
        #1;
        rst = 1'b1;
        expect_at(pk(0, 0, 0, 1'b0, 1'b1), 0, "rst_async");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Right edge after reset.
        launch(790, 300, 3);
        tick_start(); expect_at(pk(794, 300, 3, 1'b0, 1'b0), 1, "right_1"); tick_end();
        tick_start(); expect_at(pk(798, 300, 3, 1'b0, 1'b0), 1, "right_2"); tick_end();
        tick_start(); expect_at(pk(798, 300, 0, 1'b0, 1'b0), 1, "right_edge"); tick_end();
        cooldown(798, 300);

        // Target hit on the third tick, one-clk pulse.
        xpos_target = 10'd100; ypos_target = 10'd150;
        launch(110, 200, 1);
        tick_start(); expect_at(pk(110, 196, 1, 1'b0, 1'b0), 1, "hit_1"); tick_end();
        tick_start(); expect_at(pk(110, 192, 1, 1'b0, 1'b0), 1, "hit_2"); tick_end();
        tick_start();
        expect_at(pk(110, 188, 0, 1'b1, 1'b0), 1, "hit_pulse");
        expect_at(pk(110, 188, 0, 1'b0, 1'b0), 2, "hit_clear");
        tick_end();
        cooldown(110, 188);

        repeat (5) @(negedge clk);
        mon_en = 1'b0;
        while (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL %s: got no output change, required %h at cyc %0d",
                     e.name, e.v, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
